// File: rtl/peripheral_ahb3_pkg.sv
// peripheral_ahb3_pkg: AHB3-Lite encodings shared by the peripheral bridges,
// plus the APB-to-AHB bridge FSM states and strobe-decode result.
package peripheral_ahb3_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HWORD   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP, ST_DRAIN} apb2ahb3_state_t;
  typedef struct packed {
    logic [2:0] hsize;
    logic [1:0] offset;
    logic       is_null;
    logic       illegal;
  } apb2ahb3_dec_t;
endpackage

// File: rtl/peripheral_apb2ahb3_strb_decode.sv
// peripheral_apb2ahb3_strb_decode: maps an APB write strobe onto an AHB size and byte offset.
module peripheral_apb2ahb3_strb_decode
  import peripheral_ahb3_pkg::*;
(
  input  logic          pwrite,
  input  logic [3:0]    pstrb,
  output apb2ahb3_dec_t dec
);
  always_comb begin
    dec = '{hsize: HSIZE_WORD, offset: 2'd0, is_null: 1'b0, illegal: 1'b0};
    if (pwrite)
      case (pstrb)
        4'b0000: dec.is_null = 1'b1;
        4'b1111: ;
        4'b0011: dec.hsize = HSIZE_HWORD;
        4'b1100: begin dec.hsize = HSIZE_HWORD; dec.offset = 2'd2; end
        4'b0001: dec.hsize = HSIZE_BYTE;
        4'b0010: begin dec.hsize = HSIZE_BYTE; dec.offset = 2'd1; end
        4'b0100: begin dec.hsize = HSIZE_BYTE; dec.offset = 2'd2; end
        4'b1000: begin dec.hsize = HSIZE_BYTE; dec.offset = 2'd3; end
        default: dec.illegal = 1'b1;
      endcase
  end
endmodule

// File: rtl/peripheral_apb2ahb3.sv
// peripheral_apb2ahb3: APB4 slave to AHB3-Lite master bridge, one SINGLE AHB transfer per APB access.
// Define PERIPHERAL_APB2AHB3_TIMEOUT_EN for the HREADY-low timeout with post-timeout drain.
module peripheral_apb2ahb3
  import peripheral_ahb3_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 32,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 255
)(
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [PDATA_SIZE-1:0] PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  output logic [PDATA_SIZE-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic                  HRESP
);
  apb2ahb3_state_t state, state_nxt;
  apb2ahb3_dec_t dec;
  logic aborted, abort_now, accept, tmo_hit, drain_req, unused_ok;
  logic [PDATA_SIZE-1:0] rd_lane;

  peripheral_apb2ahb3_strb_decode u_dec (.pwrite(PWRITE), .pstrb(PSTRB), .dec(dec));

  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign abort_now = aborted | ~PSEL;
  assign rd_lane   = (HDATA_SIZE == 64 && HADDR[2]) ? HRDATA[HDATA_SIZE-1 -: PDATA_SIZE] : HRDATA[PDATA_SIZE-1:0];
  assign unused_ok = ^{PPROT[1], PADDR[1:0], TIMEOUT[0]};

`ifdef PERIPHERAL_APB2AHB3_TIMEOUT_EN
  localparam int CW = TIMEOUT > 255 ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;
  logic timed_out, held;
  // held remembers an APB access that arrived while draining, so it is taken in IDLE despite PENABLE=1
  assign tmo_hit   = (state == ST_ADDR || state == ST_DATA) && !HREADY && cnt == CW'(TIMEOUT - 1);
  assign accept    = PSEL & (~PENABLE | held);
  assign drain_req = timed_out & ~HREADY;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      cnt       <= '0;
      timed_out <= 1'b0;
      held      <= 1'b0;
    end else begin
      cnt       <= ((state == ST_ADDR || state == ST_DATA) && !HREADY) ? cnt + 1'b1 : '0;
      timed_out <= tmo_hit ? 1'b1 : (state == ST_IDLE) ? 1'b0 : timed_out;
      held      <= (state == ST_DRAIN) ? (held | PSEL) : (state == ST_IDLE) ? 1'b0 : held;
    end
`else
  assign tmo_hit   = 1'b0;
  assign accept    = PSEL & ~PENABLE;
  assign drain_req = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= ST_IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (dec.is_null || dec.illegal) ? ST_RESP : ST_ADDR;
      ST_ADDR: state_nxt = tmo_hit ? (abort_now ? ST_DRAIN : ST_RESP) : HREADY ? ST_DATA : ST_ADDR;
      ST_DATA: state_nxt = tmo_hit ? (abort_now ? ST_DRAIN : ST_RESP) : HREADY ? (abort_now ? ST_IDLE : ST_RESP) : ST_DATA;
      ST_RESP: state_nxt = drain_req ? ST_DRAIN : ST_IDLE;
      default: state_nxt = HREADY ? ST_IDLE : ST_DRAIN;
    endcase
  end

  always_comb begin
    PREADY = state == ST_RESP;
    HTRANS = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      HADDR   <= '0;
      HWRITE  <= 1'b0;
      HSIZE   <= '0;
      HPROT   <= '0;
      HWDATA  <= '0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      aborted <= 1'b0;
    end else begin
      if (state == ST_IDLE && accept) begin
        HADDR   <= HADDR_SIZE'({PADDR[PADDR_SIZE-1:2], dec.offset});
        HWRITE  <= PWRITE;
        HSIZE   <= dec.hsize;
        HPROT   <= {2'b00, PPROT[0], ~PPROT[2]};
        HWDATA  <= {(HDATA_SIZE/PDATA_SIZE){PWDATA}};
        PSLVERR <= dec.illegal;
        aborted <= 1'b0;
      end
      if (state == ST_ADDR || state == ST_DATA) aborted <= abort_now;
      if (state == ST_DATA && HREADY && !abort_now) begin
        PSLVERR <= HRESP == HRESP_ERROR;
        if (!HWRITE) PRDATA <= rd_lane;
      end
      if (tmo_hit) PSLVERR <= 1'b1;
    end
endmodule

// File: tb/tb_peripheral_apb2ahb3.sv
// tb_peripheral_apb2ahb3: randomized APB master and scripted AHB slave checked against
// transaction-level expectations (decode table, latency 3+waits, read data, error).
`timescale 1ns/1ps
module tb_peripheral_apb2ahb3;
`ifdef PERIPHERAL_APB2AHB3_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif
  logic HRESETn, HCLK, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [31:0] PADDR, PWDATA, PRDATA, HADDR, HWDATA, HRDATA;
  logic [3:0] PSTRB, HPROT;
  logic [2:0] PPROT, HSIZE, HBURST;
  logic [1:0] HTRANS;
  int checks = 0, errors = 0;
  logic [31:0] last_prdata = 0;
  logic [3:0] strb_tab [8] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

  peripheral_apb2ahb3 #(.TIMEOUT(TMO)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic w, input logic [3:0] s, output bit xfer,
                                     output bit serr, output logic [2:0] sz, output logic [1:0] off);
    xfer = 1; serr = 0; sz = 3'd2; off = 2'd0;
    if (!w) return;
    if (s == 4'h0) xfer = 0;
    else if (s == 4'hF) sz = 3'd2;
    else if (s == 4'h3 || s == 4'hC) begin sz = 3'd1; off = s[2] ? 2'd2 : 2'd0; end
    else if ($countones(s) == 1) begin sz = 3'd0; off = 2'($clog2(s)); end
    else begin xfer = 0; serr = 1; end
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      check("idle_htrans", HTRANS, 2'b00);
      check("idle_pready", PREADY, 1'b0);
      PSEL = 0; PENABLE = 0; HREADY = 1; HRESP = 0; HRDATA = $urandom;
    end
  endtask

  // One APB access; the AHB slave inserts wa address-phase and wdw data-phase waits.
  task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] s,
                          input logic [2:0] p, input int wa, input int wdw, input bit herr, input logic [31:0] rd);
    bit xfer, serr;
    logic [2:0] sz;
    logic [1:0] off;
    int done;
    ref_decode(w, s, xfer, serr, sz, off);
    done = xfer ? 3 + wa + wdw : 1;
    for (int k = 0; k <= done; k++) begin
      @(negedge HCLK);
      check("htrans", HTRANS, (xfer && k >= 1 && k <= 1 + wa) ? 2'b10 : 2'b00);
      check("pready", PREADY, k == done);
      if (xfer && k == 1) begin
        check("haddr", HADDR, {a[31:2], off});
        check("hsize", HSIZE, sz);
        check("hwrite", HWRITE, w);
        check("hprot", HPROT, {2'b00, p[0], ~p[2]});
      end
      if (xfer && w && k == 2 + wa) check("hwdata", HWDATA, wd);
      if (k == done) begin
        if (xfer && !w) last_prdata = rd;
        check("pslverr", PSLVERR, xfer ? herr : serr);
        check("prdata", PRDATA, last_prdata);
      end
      PSEL = 1; PENABLE = k > 0; PADDR = a; PWRITE = w; PWDATA = wd; PSTRB = s; PPROT = p;
      if (xfer && k >= 1 && k <= 1 + wa) HREADY = k == 1 + wa;
      else if (xfer && k >= 2 + wa && k <= 2 + wa + wdw) HREADY = k == 2 + wa + wdw;
      else HREADY = 1'($urandom);
      HRESP = herr && xfer && k >= 1 + wa + wdw && k <= 2 + wa + wdw;
      HRDATA = (k == 2 + wa + wdw) ? rd : $urandom;
    end
  endtask

  initial begin
    HRESETn = 0; PSEL = 0; PENABLE = 0; PADDR = 0; PWRITE = 0; PWDATA = 0; PSTRB = 0; PPROT = 0;
    HREADY = 1; HRESP = 0; HRDATA = 0;
    repeat (3) @(negedge HCLK);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_pready", PREADY, 1'b0);
    check("rst_pslverr", PSLVERR, 1'b0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_hsize", HSIZE, 3'b000);
    check("rst_hprot", HPROT, 4'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("hburst", HBURST, 3'b000);
    check("hmastlock", HMASTLOCK, 1'b0);
    HRESETn = 1;
    idle(2);

    apb_xfer(32'h100, 1, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, 32'h0);
    idle(1);
    apb_xfer(32'h204, 0, 32'h0, 4'h0, 3'b101, 0, 2, 0, 32'h12345678);
    apb_xfer(32'h40, 1, 32'hA5A5A5A5, 4'b0100, 3'b001, 0, 0, 0, 32'h0);
    apb_xfer(32'h40, 1, 32'h5A5A5A5A, 4'b1100, 3'b000, 1, 0, 0, 32'h0);
    apb_xfer(32'h40, 1, 32'h11111111, 4'b0101, 3'b000, 0, 0, 0, 32'h0);
    apb_xfer(32'h40, 1, 32'h22222222, 4'b0000, 3'b000, 0, 0, 0, 32'h0);
    apb_xfer(32'h80, 0, 32'h0, 4'h0, 3'b000, 0, 1, 1, 32'hCAFEF00D);
    idle(1);

    // PSEL dropped in the data phase: transfer completes, no PREADY, PRDATA kept
    for (int k = 0; k <= 8; k++) begin
      @(negedge HCLK);
      check("abort_pready", PREADY, 1'b0);
      check("abort_htrans", HTRANS, k == 1 ? 2'b10 : 2'b00);
      PSEL = k < 2; PENABLE = k == 1; PADDR = 32'h500; PWRITE = 0;
      HREADY = k == 1 || k >= 4; HRESP = 0; HRDATA = 32'hBAD0BAD0;
    end
    check("abort_prdata", PRDATA, last_prdata);
    apb_xfer(32'h504, 0, 32'h0, 4'h0, 3'b010, 0, 0, 0, 32'h600DD00D);

    // asynchronous reset while the data phase is stalled
    for (int k = 0; k <= 3; k++) begin
      @(negedge HCLK);
      PSEL = 1; PENABLE = k > 0; PADDR = 32'h700; PWRITE = 0; HREADY = k == 1; HRESP = 0;
    end
    #1 HRESETn = 0;
    #1;
    check("rstmid_htrans", HTRANS, 2'b00);
    check("rstmid_pready", PREADY, 1'b0);
    check("rstmid_prdata", PRDATA, 32'h0);
    check("rstmid_haddr", HADDR, 32'h0);
    last_prdata = 0;
    PSEL = 0; PENABLE = 0; HREADY = 1;
    @(negedge HCLK);
    HRESETn = 1;
    idle(2);

`ifdef PERIPHERAL_APB2AHB3_TIMEOUT_EN
    // HREADY low for cycles 1..10: timeout response at 5, next access stalls until drain ends
    for (int k = 0; k <= 15; k++) begin
      @(negedge HCLK);
      check("tmo_pready", PREADY, k == 5 || k == 15);
      check("tmo_htrans", HTRANS, ((k >= 1 && k <= 4) || k == 13) ? 2'b10 : 2'b00);
      if (k == 5) begin
        check("tmo_pslverr", PSLVERR, 1'b1);
        check("tmo_prdata", PRDATA, last_prdata);
      end
      if (k == 15) begin
        last_prdata = 32'h7E57DA7A;
        check("tmo_next_pslverr", PSLVERR, 1'b0);
        check("tmo_next_prdata", PRDATA, last_prdata);
      end
      PSEL = 1; PENABLE = k > 0 && k != 6; PWRITE = 0;
      PADDR = k <= 5 ? 32'h300 : 32'h304;
      HREADY = !(k >= 1 && k <= 10); HRESP = 0;
      HRDATA = k == 14 ? 32'h7E57DA7A : $urandom;
    end
    idle(1);
`endif

    for (int t = 0; t < 40; t++) begin
      logic w;
      logic [3:0] s;
      bit herr;
      int wdw;
      w = 1'($urandom);
      s = $urandom_range(0, 3) != 0 ? strb_tab[$urandom_range(0, 7)] : 4'($urandom);
      herr = $urandom_range(0, 4) == 0;
      wdw = herr ? $urandom_range(1, 2) : $urandom_range(0, 2);
      apb_xfer($urandom, w, $urandom, s, 3'($urandom), $urandom_range(0, 2), wdw, herr, $urandom);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/peripheral_apb2ahb3.md
Name: peripheral_apb2ahb3

Overview:
- APB4 slave port to AHB3-Lite master bridge, single clock domain (HCLK).
- Lets an APB-attached initiator (debug/config agent, APB-side DMA) issue single transfers into the AHB3-Lite interconnect.
- It is the inverse direction of our AHB-to-APB peripheral bridge.
- Each APB access produces exactly zero or one AHB SINGLE transfer. No bursts, no posting.

Parameters:
- HADDR_SIZE, 32, AHB address width.
- HDATA_SIZE, 32, AHB data width; legal values 32 or 64.
- PADDR_SIZE, 32, APB address width; must be <= HADDR_SIZE; zero-extended onto HADDR.
- PDATA_SIZE, 32, APB data width; fixed at 32.
- TIMEOUT, 255, maximum HREADY-low cycles per AHB transfer (used only with the optional feature).

Ports:
- HRESETn  in  1  asynchronous active-low reset
- HCLK  in  1  clock (shared by APB and AHB sides)
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PADDR  in  PADDR_SIZE  APB address
- PWRITE  in  1  APB direction
- PWDATA  in  32  APB write data
- PSTRB  in  4  APB write byte strobes
- PPROT  in  3  APB protection
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error
- HADDR  out  HADDR_SIZE  AHB address
- HWDATA  out  HDATA_SIZE  AHB write data
- HRDATA  in  HDATA_SIZE  AHB read data
- HWRITE  out  1  AHB direction
- HSIZE  out  3  AHB size
- HBURST  out  3  constant SINGLE
- HPROT  out  4  AHB protection
- HTRANS  out  2  AHB transfer type
- HMASTLOCK  out  1  constant 0
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB response

Behaviour:
- Reset (async, immediate): FSM=IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HPROT=0, HWDATA=0, PREADY=0, PSLVERR=0, PRDATA=0. Reset mid-transfer abandons it with no APB response.
- States: IDLE, ADDR, DATA, RESP, DRAIN (DRAIN exists only with the optional feature).
- IDLE: on PSEL & !PENABLE (setup phase), latch and decode the request, then:
  - Valid request: drive the AHB address phase next cycle (HTRANS=NONSEQ) and go to ADDR.
  - Null write (PWRITE & PSTRB==0): go to RESP with PSLVERR=0; no AHB transfer.
  - Illegal strobe: go to RESP with PSLVERR=1; no AHB transfer.
- Strobe decode (writes):
  - 1111 -> WORD, offset 0.
  - 0011 / 1100 -> HWORD, offset 0 / 2.
  - Single bit n -> BYTE, offset n.
  - Any other non-zero pattern is illegal.
- Reads ignore PSTRB: always WORD, offset 0.
- HADDR = {PADDR[..:2], offset}.
- HPROT = {2'b00, PPROT[0], ~PPROT[2]} (privileged, data/opcode).
- ADDR: hold address-phase signals until HREADY=1. Then HTRANS=IDLE and go to DATA; HWDATA carries PWDATA.
  - HDATA_SIZE=64: PWDATA is replicated on both 32-bit lanes.
- DATA: wait for HREADY=1.
  - Capture the HRDATA lane (lane PADDR[2] when 64-bit) into PRDATA.
  - PSLVERR = HRESP.
  - Go to RESP.
  - HRESP=ERROR first cycle (HREADY=0) is simply waited through.
- RESP: PREADY=1 for exactly one cycle, then IDLE; PREADY=0 otherwise. PRDATA holds until the next read completes.
- Minimum latency, zero-wait AHB: setup at T0, PREADY=1 at T3.
- PSEL deasserted mid-operation: the AHB transfer still completes; the result is discarded; FSM returns to IDLE without PREADY.
- Back-to-back APB accesses: a new setup is accepted only in IDLE.

Optional Feature:
- Macro: PERIPHERAL_APB2AHB3_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter counts consecutive HREADY-low cycles in ADDR/DATA.
  - When the count reaches TIMEOUT, go to RESP with PSLVERR=1 and PRDATA unchanged.
  - If the AHB transfer has not finished, enter DRAIN after RESP. DRAIN keeps HTRANS=IDLE until HREADY=1, then goes to IDLE. New APB setups stall (PREADY=0) until then.
  - The counter clears on entry to ADDR.
- Undefined: no counter and no DRAIN; the bridge waits indefinitely.

Decomposition:
- AHB encodings (HTRANS_*, HSIZE_*, HBURST_SINGLE, HRESP_*) come from the existing peripheral_ahb3_pkg.
- Add to that package the bridge FSM state enum and a struct {hsize, offset, null, illegal} for the decode result.
- Sub-module peripheral_apb2ahb3_strb_decode: combinational PSTRB/PWRITE/PADDR -> decode struct; unit-testable on its own.

Test Plan:
- APB write PADDR=0x100, PSTRB=1111, PWDATA=0xDEADBEEF, AHB zero-wait -> one NONSEQ: HADDR=0x100, HSIZE=WORD, HWRITE=1, HWDATA=0xDEADBEEF; PREADY=1 at T3, PSLVERR=0.
- APB read PADDR=0x204, AHB inserts 2 wait states, HRDATA=0x12345678 -> PRDATA=0x12345678, PREADY at T5, HTRANS=IDLE throughout the data phase.
- Writes with PSTRB=0100 and PSTRB=1100 to 0x40 -> HADDR=0x42 HSIZE=BYTE, then HADDR=0x42 HSIZE=HWORD.
- PSTRB=0101 -> PSLVERR=1 and PSTRB=0000 -> PSLVERR=0, both with no AHB activity (HTRANS stays IDLE).
- AHB two-cycle HRESP=ERROR on a read -> PSLVERR=1, PREADY=1 one cycle after the second error cycle.
- Timeout (macro defined, TIMEOUT=4), HREADY held low for 10 cycles -> PSLVERR=1 after 4 cycles; the next APB setup stalls until HREADY rises. HRESETn asserted mid-DATA -> HTRANS=IDLE and PREADY=0 immediately.
